// File: rtl/riscv_instr_encoder_if.sv
// Field-bundle and encoded-word handshake bundle for the RV32I instruction encoder.
// master drives fields and out_ready; slave is the encoder.
interface riscv_instr_encoder_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       fmt;
  logic [6:0]       opcode;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [31:0]      imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      instr;
  logic             err;
  logic [CNT_W-1:0] count;

  modport master (
    output in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    input  in_ready, out_valid, instr, err, count
  );

  modport slave (
    input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    output in_ready, out_valid, instr, err, count
  );
endinterface

// File: rtl/riscv_instr_encoder.sv
// Two-stage RV32I instruction encoder: S1 captures raw fields and range-checks the
// immediate, S2 holds the packed word that drives the outputs straight from flops.
module riscv_instr_encoder #(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  riscv_instr_encoder_if.slave bus
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  function automatic logic is_shift(input logic [2:0] f, input logic [6:0] op,
                                    input logic [2:0] f3);
    return (f == FMT_I) && (op == OP_IMM) && ((f3 == 3'b001) || (f3 == 3'b101));
  endfunction

  // True when the immediate cannot be represented in the chosen format.
  function automatic logic range_err(input logic [2:0] f, input logic [6:0] op,
                                     input logic [2:0] f3, input logic [31:0] v);
    logic e;
    case (f)
      FMT_R: e = 1'b0;
      FMT_I: begin
        if (is_shift(f, op, f3)) begin
          e = (v[31:5] != {27{1'b0}});
        end else begin
          e = !((v[31:11] == {21{1'b0}}) || (v[31:11] == {21{1'b1}}));
        end
      end
      FMT_S: e = !((v[31:11] == {21{1'b0}}) || (v[31:11] == {21{1'b1}}));
      FMT_B: e = !((v[31:12] == {20{1'b0}}) || (v[31:12] == {20{1'b1}})) || v[0];
      FMT_U: e = (v[11:0] != 12'h000);
      FMT_J: e = !((v[31:20] == {12{1'b0}}) || (v[31:20] == {12{1'b1}})) || v[0];
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] encode(input logic [2:0] f, input logic [6:0] op,
                                         input logic [4:0] d, input logic [4:0] s1,
                                         input logic [4:0] s2, input logic [2:0] f3,
                                         input logic [6:0] f7, input logic [31:0] v);
    logic [31:0] w;
    case (f)
      FMT_R: w = {f7, s2, s1, f3, d, op};
      FMT_I: begin
        if (is_shift(f, op, f3)) begin
          w = {f7, v[4:0], s1, f3, d, op};
        end else begin
          w = {v[11:0], s1, f3, d, op};
        end
      end
      FMT_S: w = {v[11:5], s2, s1, f3, v[4:0], op};
      FMT_B: w = {v[12], v[10:5], s2, s1, f3, v[4:1], v[11], op};
      FMT_U: w = {v[31:12], d, op};
      FMT_J: w = {v[20], v[10:1], v[11], v[19:12], d, op};
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  logic             s1_v_r;
  logic [2:0]       s1_fmt_r;
  logic [6:0]       s1_opcode_r;
  logic [4:0]       s1_rd_r;
  logic [4:0]       s1_rs1_r;
  logic [4:0]       s1_rs2_r;
  logic [2:0]       s1_funct3_r;
  logic [6:0]       s1_funct7_r;
  logic [31:0]      s1_imm_r;
  logic             s1_err_r;
  logic             s2_v_r;
  logic [31:0]      instr_r;
  logic             err_r;
  logic [CNT_W-1:0] count_r;

  logic             s2_adv_s;
  logic             in_ready_s;
  logic             in_fire_s;
  logic             out_fire_s;
  logic             in_err_s;
  logic [31:0]      enc_s;

  // Handshake/advance decisions and the combinational encode of the S1 contents.
  always_comb begin
    s2_adv_s   = s1_v_r && (!s2_v_r || bus.out_ready);
    in_ready_s = !s1_v_r || s2_adv_s;
    in_fire_s  = bus.in_valid && in_ready_s;
    out_fire_s = s2_v_r && bus.out_ready;
    in_err_s   = range_err(bus.fmt, bus.opcode, bus.funct3, bus.imm);
    enc_s      = encode(s1_fmt_r, s1_opcode_r, s1_rd_r, s1_rs1_r, s1_rs2_r,
                        s1_funct3_r, s1_funct7_r, s1_imm_r);
  end

  // Stage 1: capture the raw field bundle and its range verdict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_r      <= 1'b0;
      s1_fmt_r    <= 3'd0;
      s1_opcode_r <= 7'd0;
      s1_rd_r     <= 5'd0;
      s1_rs1_r    <= 5'd0;
      s1_rs2_r    <= 5'd0;
      s1_funct3_r <= 3'd0;
      s1_funct7_r <= 7'd0;
      s1_imm_r    <= 32'd0;
      s1_err_r    <= 1'b0;
    end else if (in_fire_s) begin
      s1_v_r      <= 1'b1;
      s1_fmt_r    <= bus.fmt;
      s1_opcode_r <= bus.opcode;
      s1_rd_r     <= bus.rd;
      s1_rs1_r    <= bus.rs1;
      s1_rs2_r    <= bus.rs2;
      s1_funct3_r <= bus.funct3;
      s1_funct7_r <= bus.funct7;
      s1_imm_r    <= bus.imm;
      s1_err_r    <= in_err_s;
    end else if (s2_adv_s) begin
      s1_v_r <= 1'b0;
    end
  end

  // Stage 2: hold the packed word until the consumer takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v_r  <= 1'b0;
      instr_r <= 32'h0000_0000;
      err_r   <= 1'b0;
    end else if (s2_adv_s) begin
      s2_v_r  <= 1'b1;
      instr_r <= enc_s;
      err_r   <= s1_err_r;
    end else if (out_fire_s) begin
      s2_v_r <= 1'b0;
    end
  end

  // Delivered-word counter; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (out_fire_s) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = s2_v_r;
  assign bus.instr     = instr_r;
  assign bus.err       = err_r;
  assign bus.count     = count_r;

endmodule

// File: tb/tb_riscv_instr_encoder.sv
// Directed scoreboard bench for riscv_instr_encoder: expected words are queued at
// acceptance and compared by a monitor at each output handshake.
module tb_riscv_instr_encoder;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   exp_count;
  exp_t exp_q[$];

  riscv_instr_encoder_if #(.CNT_W(16)) bus ();

  riscv_instr_encoder #(.CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Output monitor: compare the word about to be taken against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_word observed=%h expected=none", bus.instr);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_instr", bus.instr, e.instr);
        chk("sb_err", {31'd0, bus.err}, {31'd0, e.err});
        exp_count++;
      end
    end
  end

  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] im,
                      input logic [31:0] ei, input logic ee);
    int n;
    bus.in_valid = 1'b1;
    bus.fmt = f; bus.opcode = op; bus.rd = d; bus.rs1 = s1; bus.rs2 = s2;
    bus.funct3 = f3; bus.funct7 = f7; bus.imm = im;
    n = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("accept", {31'd0, bus.in_ready}, 32'd1);
    if (bus.in_ready === 1'b1) exp_q.push_back('{ei, ee});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    int base;
    clk = 1'b0; rst = 1'b1;
    total = 0; bad = 0; exp_count = 0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.fmt = 3'd0; bus.opcode = 7'd0; bus.rd = 5'd0; bus.rs1 = 5'd0; bus.rs2 = 5'd0;
    bus.funct3 = 3'd0; bus.funct7 = 7'd0; bus.imm = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_instr", bus.instr, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    chk("rst_count", {16'd0, bus.count}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // addi x1,x0,5 with latency check
    send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0);
    @(negedge clk);
    chk("lat_not_yet", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    chk("lat_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("lat_instr", bus.instr, 32'h0050_0093);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    drain();
    repeat (2) @(posedge clk); #1;
    chk("count_one", {16'd0, bus.count}, 32'd1);

    // add then sw back-to-back, emitted in consecutive cycles
    send(3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h0020_81B3, 1'b0);
    send(3'd2, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8, 32'h0020_A423, 1'b0);
    @(negedge clk);
    chk("b2b_first", bus.instr, 32'h0020_81B3);
    @(negedge clk);
    chk("b2b_second", bus.instr, 32'h0020_A423);
    chk("b2b_valid", {31'd0, bus.out_valid}, 32'd1);
    drain();
    repeat (2) @(posedge clk); #1;
    chk("count_three", {16'd0, bus.count}, 32'd3);

    // branches, jumps, shifts, upper-immediate and the range boundaries
    send(3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
    send(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h0080_00EF, 1'b0);
    send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096, 32'h0000_0093, 1'b1);
    send(3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h0000_0163, 1'b1);
    send(3'd7, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0000_0000, 1'b1);
    send(3'd6, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h0000_0000, 1'b1);
    send(3'd1, 7'b0010011, 5'd5, 5'd6, 5'd0, 3'b001, 7'd0, 32'd3, 32'h0033_1293, 1'b0);
    send(3'd1, 7'b0010011, 5'd5, 5'd6, 5'd0, 3'b001, 7'd0, 32'd32, 32'h0003_1293, 1'b1);
    send(3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
    send(3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 32'h1234_52B7, 1'b1);
    send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800, 32'h8000_0093, 1'b0);
    send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2047, 32'h7FF0_0093, 1'b0);
    send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h8000_0093, 1'b1);
    send(3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4094, 32'h7E00_0FE3, 1'b0);
    send(3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096, 32'h8000_0063, 1'b1);
    send(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFE, 32'hFFFF_F0EF, 1'b0);
    send(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000, 32'h8000_00EF, 1'b1);
    drain();
    repeat (2) @(posedge clk); #1;
    chk("count_model", {16'd0, bus.count}, exp_count);

    // backpressure: two accepted, third stalls, outputs hold
    base = exp_count;
    bus.out_ready = 1'b0;
    send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h0010_0093, 1'b0);
    send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 32'h0020_0093, 1'b0);
    bus.in_valid = 1'b1; bus.imm = 32'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_hold_instr", bus.instr, 32'h0010_0093);
      chk("bp_hold_err", {31'd0, bus.err}, 32'd0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
    if (bus.in_ready === 1'b1) exp_q.push_back('{32'h0030_0093, 1'b0});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    drain();
    repeat (2) @(posedge clk); #1;
    chk("bp_count", {16'd0, bus.count}, base + 3);

    // asynchronous reset with two bundles in flight
    bus.out_ready = 1'b0;
    send(3'd1, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 32'h0070_0113, 1'b0);
    send(3'd1, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h0080_0113, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_count", {16'd0, bus.count}, 32'd0);
    chk("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("arst_instr", bus.instr, 32'd0);
    exp_q.delete();
    exp_count = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_idle", {31'd0, bus.out_valid}, 32'd0);
    end
    @(posedge clk); #1;
    send(3'd1, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0);
    drain();
    repeat (2) @(posedge clk); #1;
    chk("post_rst_count", {16'd0, bus.count}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_instr_encoder.md
Name: riscv_instr_encoder

Overview:
- Pipelined RV32I instruction encoder. It is the inverse of the core's field decoder.
- Takes opcode, format, register, funct and immediate fields and produces the packed 32-bit instruction word.
- Used by the self-test instruction generator and the boot-ROM loader to build instruction memory images.
- Two-stage pipeline with valid/ready handshakes on both sides. It flags immediates that cannot be encoded.

Parameters:
CNT_W, 16, width of the emitted-instruction counter.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  field bundle valid
in_ready  output  1  encoder can accept a bundle this cycle
fmt  input  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal
opcode  input  7  major opcode, copied to instr[6:0]
rd  input  5  destination register
rs1  input  5  source register 1
rs2  input  5  source register 2
funct3  input  3  funct3 field
funct7  input  7  funct7 field (R format and shift-immediate only)
imm  input  32  signed immediate; byte offset for B/J; full 32-bit value for U
out_valid  output  1  encoded word valid
out_ready  input  1  consumer accepts the word
instr  output  32  encoded instruction
err  output  1  the instr word carries a range/format error
count  output  CNT_W  number of words delivered (out handshakes), wraps at 2^CNT_W

Behaviour:
- Reset (asynchronous, active-high): both stage valids=0, in_ready=1, out_valid=0, instr=0, err=0, count=0. Reset mid-operation discards all in-flight bundles.
- Input handshake fires on in_valid&&in_ready at a rising edge. Output handshake fires on out_valid&&out_ready.
- S1 registers the raw fields and computes err. S2 holds the assembled instr/err, which drive the outputs directly from flops.
- Advance rules:
  - s2_adv = s1_v && (!s2_v || out_ready).
  - in_ready = !s1_v || s2_adv. This is a combinational path from out_ready; it is intended.
- Latency: a bundle accepted at edge t appears on out_valid/instr from edge t+1 if S2 is free. Throughput is 1 word/cycle when out_ready is held high.
- Capacity is 2 bundles. With out_ready=0, in_ready drops once both stages are full. No bundle is lost or duplicated, and order is preserved.
- instr, err and out_valid hold stable while out_valid=1 and out_ready=0.
- Field placement:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I: {imm[11:0], rs1, funct3, rd, opcode}. Exception: if opcode=0010011 and funct3 is 001 or 101, use {funct7, imm[4:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- Range rules (err=1 on violation; the word is still emitted with imm truncated as placed):
  - I/S: -2048..2047.
  - Shift-immediate: 0..31.
  - B: -4096..4094 and imm[0]=0.
  - J: -1048576..1048574 and imm[0]=0.
  - U: imm[11:0]=0.
  - R: imm ignored.
- fmt 6/7: instr=32'h0, err=1.
- count increments by 1 on every output handshake. It wraps from all-ones to 0.
- Simultaneous input and output handshake in the same cycle: both take effect, and occupancy is unchanged.

Test Plan:
- I: opcode=0010011, rd=1, rs1=0, f3=0, imm=5 -> instr=0x00500093, err=0; out_valid one edge after acceptance.
- R then S, back-to-back, out_ready=1:
  - add x3,x1,x2 -> 0x002081B3.
  - sw x2,8(x1) (opcode 0100011, f3=010, imm=8) -> 0x0020A423.
  - Both appear in consecutive cycles; count=2.
- B and J: beq x0,x0,-4 (opcode 1100011) -> 0xFE000EE3; jal x1,8 (opcode 1101111) -> 0x008000EF.
- Errors:
  - I-type addi x1,x0 with imm=4096 -> instr=0x00000093, err=1.
  - B with imm=3 -> err=1.
  - fmt=7 -> instr=0, err=1.
- Backpressure: hold out_ready=0 and offer 3 bundles -> in_ready=0 after 2 accepts; instr stable. Release -> 3 words delivered in order; count=3.
- Reset: assert rst with 2 bundles in flight -> out_valid=0, count=0 immediately (asynchronous); no stale word after deassert.
